// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers per-digit BCD, decimal point and error flags from a multiplexed 7-segment bus; SEG7_FILTER_EN adds the stability filter.
// Latency: commit STABLE_CNT-1 edges after a pattern first appears (same edge without the filter); frame_done one edge after the completing commit.
// Backpressure: none; a passive monitor that samples every cycle and never stalls the display path.
module seg7_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          seg,
    input  logic [NDIG-1:0]     dig_en,
    output logic [4*NDIG-1:0]   bcd,
    output logic [NDIG-1:0]     dp,
    output logic [NDIG-1:0]     valid,
    output logic [NDIG-1:0]     err,
    output logic                frame_done
);

    if (NDIG < 1) begin : g_bad_ndig
        $error("seg7_scan_reader: NDIG must be at least 1");
    end
    if (STABLE_CNT < 1) begin : g_bad_stable_cnt
        $error("seg7_scan_reader: STABLE_CNT must be at least 1");
    end

    typedef struct packed {
        logic [NDIG-1:0] dig_en;
        logic [7:0]      seg;
    } sample_t;

    sample_t         cur;
    logic            scan_ok;
    logic            commit;
    logic            dec_hit;
    logic            blank;
    logic [3:0]      dec_val;
    logic [NDIG-1:0] seen;
    logic [NDIG-1:0] seen_base;
    logic            seen_full;

    assign cur     = {dig_en, seg};
    // Blanking (no digit) and ghosting (several digits) are both ignored.
    assign scan_ok = $onehot(dig_en);
    assign blank   = (seg[6:0] == 7'h00);

    always_comb begin
        dec_hit = 1'b1;
        dec_val = 4'd0;
        case (seg[6:0])
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            default: dec_hit = 1'b0;
        endcase
    end

`ifdef SEG7_FILTER_EN
    localparam int CW = $clog2(STABLE_CNT + 1);

    sample_t        prev;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [CW:0]    cnt_inc;

    // Commit only on the edge the run length first reaches STABLE_CNT, so a
    // held pattern saturates instead of recommitting.
    always_comb begin
        cnt_inc = {1'b0, cnt} + (CW+1)'(1);
        cnt_nxt = CW'(1);
        commit  = 1'b0;
        if (!scan_ok) begin
            cnt_nxt = '0;
        end else if (cur == prev && cnt != '0) begin
            if (cnt_inc >= (CW+1)'(STABLE_CNT))
                cnt_nxt = CW'(STABLE_CNT);
            else
                cnt_nxt = cnt_inc[CW-1:0];
            commit = (cnt_inc == (CW+1)'(STABLE_CNT));
        end else begin
            commit = (STABLE_CNT == 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= cur;
            cnt  <= cnt_nxt;
        end
    end
`else
    assign commit = scan_ok;
`endif

    // A full mask is held for one cycle; the following edge pulses frame_done
    // and restarts the mask, keeping any commit on that edge for the next frame.
    assign seen_full = (seen == '1);
    assign seen_base = seen_full ? '0 : seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd        <= '0;
            dp         <= '0;
            valid      <= '0;
            err        <= '0;
            frame_done <= 1'b0;
            seen       <= '0;
        end else begin
            frame_done <= seen_full;
            seen       <= commit ? (seen_base | cur.dig_en) : seen_base;
            if (commit) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (cur.dig_en[i]) begin
                        dp[i] <= cur.seg[7];
                        if (dec_hit) begin
                            bcd[4*i +: 4] <= dec_val;
                            valid[i]      <= 1'b1;
                            err[i]        <= 1'b0;
                        end else if (blank) begin
                            valid[i] <= 1'b0;
                            err[i]   <= 1'b0;
                        end else begin
                            valid[i] <= 1'b0;
                            err[i]   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NDIG=4, STABLE_CNT=3); expectations follow whether SEG7_FILTER_EN is defined.
module tb_seg7_scan_reader;

    localparam int NDIG       = 4;
    localparam int STABLE_CNT = 3;
`ifdef SEG7_FILTER_EN
    localparam int LAT  = STABLE_CNT;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit FILT = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [7:0]        seg;
    logic [NDIG-1:0]   dig_en;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   valid;
    logic [NDIG-1:0]   err;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE_CNT(STABLE_CNT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .dig_en     (dig_en),
        .bcd        (bcd),
        .dp         (dp),
        .valid      (valid),
        .err        (err),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] de, input logic [7:0] s, input int n);
        dig_en = de;
        seg    = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        dig_en = '0;
        seg    = '0;
        #12;
        chk("rst_bcd",   32'(bcd),        32'h0);
        chk("rst_dp",    32'(dp),         32'h0);
        chk("rst_valid", 32'(valid),      32'h0);
        chk("rst_err",   32'(err),        32'h0);
        chk("rst_fd",    32'(frame_done), 32'h0);
        #1 rst_n = 1'b1;

        // full scan 1,2,3(dp),4
        hold(4'h1, 8'h06, LAT);
        chk("scan_d0_bcd",   32'(bcd[3:0]), 32'h1);
        chk("scan_d0_valid", 32'(valid),    32'h1);
        hold(4'h2, 8'h5B, LAT);
        hold(4'h4, 8'hCF, LAT);
        hold(4'h8, 8'h66, LAT);
        chk("scan_bcd",   32'(bcd),        32'h4321);
        chk("scan_valid", 32'(valid),      32'hF);
        chk("scan_dp",    32'(dp),         32'h4);
        chk("scan_err",   32'(err),        32'h0);
        chk("scan_fd_lo", 32'(frame_done), 32'h0);
        hold(4'h0, 8'h00, 1);
        chk("scan_fd_hi", 32'(frame_done), 32'h1);
        hold(4'h0, 8'h00, 1);
        chk("scan_fd_end", 32'(frame_done), 32'h0);
        chk("scan_fd_cnt", 32'(fd_cnt),     32'd1);

        // glitch: short run of 8 then a full run of 9
        hold(4'h1, 8'h7F, 2);
        chk("glitch_short", 32'(bcd[3:0]), FILT ? 32'h1 : 32'h8);
        hold(4'h1, 8'h6F, 2);
        chk("glitch_mid",   32'(bcd[3:0]), FILT ? 32'h1 : 32'h9);
        hold(4'h1, 8'h6F, 1);
        chk("glitch_nine",  32'(bcd[3:0]), 32'h9);

        // unrecognised then blank on digit 1
        hold(4'h2, 8'h49, LAT);
        chk("bad_err",   32'(err),      32'h2);
        chk("bad_valid", 32'(valid),    32'hD);
        chk("bad_bcd1",  32'(bcd[7:4]), 32'h2);
        hold(4'h2, 8'h00, LAT);
        chk("blank_err",   32'(err),      32'h0);
        chk("blank_valid", 32'(valid),    32'hD);
        chk("blank_bcd1",  32'(bcd[7:4]), 32'h2);

        // multi-hot and zero selects never commit
        hold(4'h3, 8'h3F, 5);
        hold(4'h0, 8'h3F, 5);
        chk("nohot_bcd",   32'(bcd),    32'h4329);
        chk("nohot_valid", 32'(valid),  32'hD);
        chk("nohot_err",   32'(err),    32'h0);
        chk("nohot_dp",    32'(dp),     32'h4);
        chk("nohot_fd",    32'(fd_cnt), 32'd1);

        // complete the second frame; long hold on the last digit
        hold(4'h4, 8'hCF, LAT);
        hold(4'h8, 8'h66, LAT + 4);
        chk("frame2_fd_cnt", 32'(fd_cnt), 32'd2);

        // single-sample run on digit 3
        hold(4'h8, 8'h07, 1);
        chk("single_edge_d3", 32'(bcd[15:12]), FILT ? 32'h4 : 32'h7);
        hold(4'h8, 8'h07, LAT - 1);
        chk("run_done_d3", 32'(bcd[15:12]), 32'h7);

        // asynchronous reset in the middle of a run
        hold(4'h2, 8'h06, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bcd",   32'(bcd),        32'h0);
        chk("arst_dp",    32'(dp),         32'h0);
        chk("arst_valid", 32'(valid),      32'h0);
        chk("arst_err",   32'(err),        32'h0);
        chk("arst_fd",    32'(frame_done), 32'h0);
        #2 rst_n = 1'b1;
        hold(4'h4, 8'h5B, LAT);
        chk("post_rst_bcd",   32'(bcd),    32'h0200);
        chk("post_rst_valid", 32'(valid),  32'h4);
        chk("post_rst_fd",    32'(fd_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Reads back a multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and recovers per-digit BCD values, decimal points and error flags. It sits on the display side of the BCD-to-7-segment path as a self-check monitor: it confirms that what the decoder drives onto the segments decodes back to the intended digits. It tolerates scan glitches with a per-sample stability filter and reports completed scan frames.

## Interface
- Parameter `NDIG`, default 4: number of multiplexed digits, at least 1.
- Parameter `STABLE_CNT`, default 3: number of consecutive identical samples needed before a commit, at least 1.
- `clk` input, 1 bit: single clock; all sampling happens on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `seg` input, 8 bits: segment lines, active-high (1 = lit). Bit 0 = a, 1 = b, 2 = c, 3 = d, 4 = e, 5 = f, 6 = g, 7 = dp. Already synchronous to `clk`.
- `dig_en` input, `NDIG` bits: digit select, active-high, expected one-hot. Bit i selects digit i.
- `bcd` output, 4*`NDIG` bits: decoded digit i in bits [4i+3:4i].
- `dp` output, `NDIG` bits: last committed decimal point for each digit.
- `valid` output, `NDIG` bits: digit i currently holds a decoded 0–9.
- `err` output, `NDIG` bits: the last commit for digit i was an unrecognized pattern.
- `frame_done` output, 1 bit: one-cycle pulse when every digit has committed at least once since the previous pulse.

## Operation
- **Sample:** each edge forms S = {`dig_en`, `seg`}. S is *scan-valid* only when `dig_en` is exactly one-hot.
- **Stability counter** (`cnt`):
  - S not scan-valid (zero or multi-hot): `cnt` <= 0 and nothing is committed. This covers blanking and ghosting intervals.
  - S scan-valid and equal to the previous sample, with `cnt` > 0: `cnt` <= min(`cnt`+1, `STABLE_CNT`).
  - Otherwise: `cnt` <= 1.
- **Commit:** happens on the edge where `cnt` transitions to `STABLE_CNT`, or when `STABLE_CNT` = 1, on every edge that sets `cnt` <= 1. There is exactly one commit per stable run; a held pattern does not recommit.
- **Decode** of seg[6:0] at commit, for selected digit i:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Recognized code: `bcd`[i] <= value, `valid`[i] <= 1, `err`[i] <= 0.
  - 0x00 (blank digit): `valid`[i] <= 0, `err`[i] <= 0, `bcd`[i] unchanged.
  - Any other code: `err`[i] <= 1, `valid`[i] <= 0, `bcd`[i] unchanged.
  - `dp`[i] <= seg[7] on every commit.
- **Frame tracking:**
  - The internal `seen`[NDIG-1:0] mask sets bit i on each commit to digit i.
  - When a commit makes `seen` all ones, `frame_done` is high for the following cycle and `seen` clears on that same edge.
  - A commit that lands during the `frame_done` cycle counts toward the next frame.

## Timing
- **Reset:** `bcd` = 0, `dp` = 0, `valid` = 0, `err` = 0, `frame_done` = 0, `cnt` = 0, `seen` = 0, previous sample = 0. Reset takes effect immediately when `rst_n` falls, including mid-run or mid-frame. After release, the first scan-valid sample starts a new run with `cnt` = 1.
- **Commit latency:** a pattern first sampled at edge k commits at edge k+`STABLE_CNT`-1. Outputs are registered and visible after that edge.
- **frame_done:** high for the cycle after the completing commit's edge, i.e. asserted at edge k+`STABLE_CNT`.
- **Run length:**
  - A run shorter than `STABLE_CNT` samples produces no output change.
  - Any change in `seg` or `dig_en` restarts the count, even within the same digit.

## Configuration
- Macro: `SEG7_FILTER_EN`.
- **Defined:** the stability filter behaves as described above, with `STABLE_CNT` in effect.
- **Undefined:**
  - `STABLE_CNT` is ignored and `cnt` logic is removed.
  - Every scan-valid sample commits on its own edge, with 1-cycle latency.
  - `frame_done` uses the same rule, driven by these per-sample commits.

## Test plan
All scenarios use `NDIG` = 4 and `STABLE_CNT` = 3 with `SEG7_FILTER_EN` defined unless stated otherwise.
1. **Reset:** assert `rst_n` = 0 mid-scan. All outputs read 0 immediately, with no wait for an edge.
2. **Full scan:** scan digits 0..3 with codes 0x06, 0x5B, 0x4F, 0x66, each held 3 cycles, dp set on digit 2. Expect `bcd` = 0x4321, `valid` = 0xF, `dp` = 0x4, `err` = 0, and a single `frame_done` pulse one cycle after digit 3 commits.
3. **Glitch rejection:** hold `dig_en` = 0x1, `seg` = 0x7F for 2 cycles, then change to 0x6F for 3 cycles. Expect `bcd`[0] = 9 after the third 0x6F edge and no intermediate 8.
4. **Invalid and blank codes:**
   - `seg` = 0x49 held 3 cycles on digit 1 gives `err`[1] = 1, `valid`[1] = 0, `bcd`[1] unchanged.
   - Then 0x00 gives `err`[1] = 0, `valid`[1] = 0.
5. **Non-one-hot select:** `dig_en` = 0x3 for 5 cycles, then 0x0 for 5 cycles. Expect no commit, all outputs unchanged, no `frame_done`.
6. **Filter compiled out:** with `SEG7_FILTER_EN` undefined, `dig_en` = 0x8, `seg` = 0x07 for 1 cycle gives `bcd`[3] = 7 after that same edge.
